// File: rtl/serial_sub_pkg.sv
// Shared FSM encodings for the bit-serial subtractor.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/serial_sub_bitsub.sv
// Single-bit full subtractor d = a - b - bin; purely combinational, zero latency, no flow control.
module bitsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor D = A - B - Bi, LSB first; result valid WIDTH edges after accept.
// One op in flight: in_ready only in IDLE, result held in HOLD until out_ready.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic             Bi,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Dout,
    output logic             Bo,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_next;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             br_next;
    logic             last;

    bitsub u_bitsub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign last      = (cnt == CW'(WIDTH - 1));

    always_comb begin
        d_next            = d_sr >> 1;
        d_next[WIDTH-1]   = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            d_sr  <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Dout  <= '0;
            Bo    <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= Ain;
                        b_sr  <= Bin;
                        br    <= Bi;
                        a_msb <= Ain[WIDTH-1];
                        b_msb <= Bin[WIDTH-1];
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    d_sr <= d_next;
                    cnt  <= cnt + CW'(1);
                    // Output registers load only on the final bit so they stay stable between results.
                    if (last) begin
                        Dout  <= d_next;
                        Bo    <= br_next;
                        Ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=5): directed cases, backpressure, reset abort, random ops.
module tb_serial_sub;

    localparam int W = 5;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic         Bi;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Dout;
    logic         Bo;
    logic         Ovf;
    logic         out_valid;
    logic         out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Ain       (Ain),
        .Bin       (Bin),
        .Bi        (Bi),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dout      (Dout),
        .Bo        (Bo),
        .Ovf       (Ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] ref_bo_d(input int a, input int b, input int bi);
        int r;
        r = (a - b - bi) & ((1 << (W + 1)) - 1);
        return r[W:0];
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int bi);
        int sa, sb, r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sa - sb - bi;
        return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for accept, then count edges until out_valid (bounded).
    task automatic send(input int a, input int b, input int bi, output int lat);
        int n;
        Ain = W'(a);
        Bin = W'(b);
        Bi  = bi[0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({in_ready, out_valid, Dout, Bo, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b Dout=%0d Bo=%b Ovf=%b, want 1 0 0 0 0",
                     in_ready, out_valid, Dout, Bo, Ovf);
        end
    endtask

    task automatic test_directed();
        int a_t[4]  = '{13, 6, 0, 15};
        int b_t[4]  = '{6, 13, 0, 31};
        int bi_t[4] = '{0, 0, 1, 0};
        int d_t[4]  = '{7, 25, 31, 16};
        int bo_t[4] = '{0, 1, 1, 1};
        int ov_t[4] = '{0, 0, 0, 1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(a_t[i], b_t[i], bi_t[i], lat);
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
            end
            n_checks++;
            if ({Dout, Bo, Ovf} !== {W'(d_t[i]), bo_t[i][0], ov_t[i][0]}) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: Dout=%0d Bo=%b Ovf=%b want %0d %0d %0d",
                         i, Dout, Bo, Ovf, d_t[i], bo_t[i], ov_t[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W+1:0] held;
        send(22, 9, 1, lat);
        held = {Dout, Bo, Ovf};
        n_checks++;
        if (held !== {W'(12), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_result: got %h want %h", held, {W'(12), 1'b0, 1'b1});
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            Ain = W'($urandom);
            Bin = W'($urandom);
            step();
            n_checks++;
            if ({Dout, Bo, Ovf, out_valid, in_ready} !== {held, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out=%h out_valid=%b in_ready=%b want %h 1 0",
                         i, {Dout, Bo, Ovf}, out_valid, in_ready, held);
            end
        end
        in_valid = 1'b0;
        consume();
        n_checks++;
        if ({out_valid, in_ready, Dout, Bo, Ovf} !== {1'b0, 1'b1, held}) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out=%h want 0 1 %h",
                     out_valid, in_ready, {Dout, Bo, Ovf}, held);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_accept: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        Ain = W'(29);
        Bin = W'(3);
        Bi  = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, Dout, Bo, Ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_async: in_ready=%b out_valid=%b Dout=%0d Bo=%b Ovf=%b want 1 0 0 0 0",
                     in_ready, out_valid, Dout, Bo, Ovf);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_lost: out_valid=%b want 0", out_valid);
        end
        send(20, 4, 0, lat);
        n_checks++;
        if ({lat[7:0], Dout, Bo, Ovf} !== {8'(W), W'(16), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_next: lat=%0d Dout=%0d Bo=%b Ovf=%b want %0d 16 0 0",
                     lat, Dout, Bo, Ovf, W);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int a, b, bi, lat, hold;
        logic [W:0] exp_bd;
        logic       exp_ov;
        for (int i = 0; i < 60; i++) begin
            a  = $urandom_range(0, (1 << W) - 1);
            b  = $urandom_range(0, (1 << W) - 1);
            bi = $urandom_range(0, 1);
            exp_bd = ref_bo_d(a, b, bi);
            exp_ov = ref_ovf(a, b, bi);
            out_ready = $urandom_range(0, 1) == 1;
            send(a, b, bi, lat);
            out_ready = 1'b0;
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, W);
            end
            n_checks++;
            if ({Bo, Dout, Ovf} !== {exp_bd, exp_ov}) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: A=%0d B=%0d Bi=%0d got Bo=%b Dout=%0d Ovf=%b want Bo=%b Dout=%0d Ovf=%b",
                         i, a, b, bi, Bo, Dout, Ovf, exp_bd[W], exp_bd[W-1:0], exp_ov);
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) step();
            n_checks++;
            if ({out_valid, Bo, Dout, Ovf} !== {1'b1, exp_bd, exp_ov}) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: out_valid=%b Bo=%b Dout=%0d Ovf=%b", i, out_valid, Bo, Dout, Ovf);
            end
            consume();
            n_checks++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        Ain       = '0;
        Bin       = '0;
        Bi        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        test_reset();
        #9;
        rst_n = 1'b1;
        step();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
